// File: rtl/mas_mac_pkg.sv
// Shared types and constants for the Vedic multiply-accumulate engine.
package mas_mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mas_mac_state_t;

  localparam int MAS_MAC_PIPE_LAT = 3;
  localparam int MAS_MUL_W        = 16;

endpackage

// File: rtl/mas_mul_vedic_16x16.sv
// Combinational 16x16 unsigned multiplier built from Urdhva-Tiryagbhyam
// (vertical and crosswise) partial products, recursively 2 -> 4 -> 8 -> 16.
module mas_mul_vedic_16x16
  import mas_mac_pkg::*;
(
  input  logic [MAS_MUL_W-1:0]   a,
  input  logic [MAS_MUL_W-1:0]   b,
  output logic [2*MAS_MUL_W-1:0] p
);

  function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
    logic       c1;
    logic [3:0] r;
    r[0] = x[0] & y[0];
    r[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
    c1   = (x[1] & y[0]) & (x[0] & y[1]);
    r[2] = (x[1] & y[1]) ^ c1;
    r[3] = (x[1] & y[1]) & c1;
    return r;
  endfunction

  function automatic logic [7:0] vedic4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] q0, q1, q2, q3;
    q0 = vedic2(x[1:0], y[1:0]);
    q1 = vedic2(x[3:2], y[1:0]);
    q2 = vedic2(x[1:0], y[3:2]);
    q3 = vedic2(x[3:2], y[3:2]);
    return {4'b0000, q0} + {2'b00, q1, 2'b00} + {2'b00, q2, 2'b00} + {q3, 4'b0000};
  endfunction

  function automatic logic [15:0] vedic8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] q0, q1, q2, q3;
    q0 = vedic4(x[3:0], y[3:0]);
    q1 = vedic4(x[7:4], y[3:0]);
    q2 = vedic4(x[3:0], y[7:4]);
    q3 = vedic4(x[7:4], y[7:4]);
    return {8'h00, q0} + {4'h0, q1, 4'h0} + {4'h0, q2, 4'h0} + {q3, 8'h00};
  endfunction

  logic [15:0] q0_s, q1_s, q2_s, q3_s;

  // Top-level crosswise combination of the four 8x8 partial products.
  always_comb begin
    q0_s = vedic8(a[7:0],  b[7:0]);
    q1_s = vedic8(a[15:8], b[7:0]);
    q2_s = vedic8(a[7:0],  b[15:8]);
    q3_s = vedic8(a[15:8], b[15:8]);
    p    = {16'h0000, q0_s} + {8'h00, q1_s, 8'h00} + {8'h00, q2_s, 8'h00} + {q3_s, 16'h0000};
  end

endmodule

// File: rtl/mas_mac_vedic_16x16.sv
// Dot-product engine: accepts len operand pairs, multiplies each through the
// Vedic multiplier and accumulates the products into an ACC_W-bit sum.
module mas_mac_vedic_16x16
  import mas_mac_pkg::*;
#(
  parameter int ACC_W = 40,
  parameter int LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        in1,
  input  logic [15:0]        in2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   acc_res,
  output logic               ovf,
  output logic               busy
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  mas_mac_state_t state_r, next_s;

  logic [LEN_W-1:0]       remaining_r;
  logic                   in_ready_r, out_valid_r, busy_r;
  logic                   v0_r, v1_r;
  logic [MAS_MUL_W-1:0]   a_r, b_r;
  logic [2*MAS_MUL_W-1:0] mul_p_s, prod_r;
  logic [ACC_W-1:0]       acc_r;
  logic                   ovf_r;
  logic [ACC_W:0]         prod_ext_s, sum_s;
  logic                   accept_s, job_start_s;

  assign accept_s    = in_valid & in_ready_r;
  assign job_start_s = (state_r == IDLE) & start;

  // Next-state decode; handshake flags are registered from the next state.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_s = (len != '0) ? RUN : DONE;
        end else begin
          next_s = IDLE;
        end
      end
      RUN: begin
        if (accept_s && (remaining_r == LEN_ONE)) begin
          next_s = DRAIN;
        end else begin
          next_s = RUN;
        end
      end
      DRAIN: begin
        if (!v0_r && !v1_r) begin
          next_s = DONE;
        end else begin
          next_s = DRAIN;
        end
      end
      DONE: begin
        if (out_ready) begin
          next_s = IDLE;
        end else begin
          next_s = DONE;
        end
      end
      default: next_s = IDLE;
    endcase
  end

  // State register, element counter and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      remaining_r <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= next_s;
      in_ready_r  <= (next_s == RUN);
      out_valid_r <= (next_s == DONE);
      busy_r      <= (next_s != IDLE);
      if (job_start_s) begin
        remaining_r <= len;
      end else if (accept_s) begin
        remaining_r <= remaining_r - LEN_ONE;
      end
    end
  end

  mas_mul_vedic_16x16 u_mul (
    .a (a_r),
    .b (b_r),
    .p (mul_p_s)
  );

  // Operand stage (S0) and product stage (S1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_r   <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      v1_r   <= 1'b0;
      prod_r <= '0;
    end else begin
      v0_r <= accept_s;
      if (accept_s) begin
        a_r <= in1;
        b_r <= in2;
      end
      v1_r <= v0_r;
      if (v0_r) begin
        prod_r <= mul_p_s;
      end
    end
  end

  // One extra bit above the accumulator captures the carry out of ACC_W-1.
  always_comb begin
    prod_ext_s                  = '0;
    prod_ext_s[2*MAS_MUL_W-1:0] = prod_r;
    sum_s                       = {1'b0, acc_r} + prod_ext_s;
  end

  // Accumulate stage (S2); result holds across IDLE until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= '0;
      ovf_r <= 1'b0;
    end else if (job_start_s) begin
      acc_r <= '0;
      ovf_r <= 1'b0;
    end else if (v1_r) begin
      acc_r <= sum_s[ACC_W-1:0];
      ovf_r <= ovf_r | sum_s[ACC_W];
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign acc_res   = acc_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_mas_mac_vedic_16x16.sv
// Directed self-checking bench; a 40-bit and a 32-bit accumulator instance share stimulus.
module tb_mas_mac_vedic_16x16;
  import mas_mac_pkg::*;

  logic        clk, rst, start, in_valid, out_ready;
  logic [7:0]  len;
  logic [15:0] in1, in2;
  logic        in_ready, out_valid, ovf, busy;
  logic [39:0] acc_res;
  logic        in_ready32, out_valid32, ovf32, busy32;
  logic [31:0] acc_res32;

  int checks   = 0;
  int failures = 0;

  mas_mac_vedic_16x16 #(.ACC_W(40), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
    .out_valid(out_valid), .out_ready(out_ready),
    .acc_res(acc_res), .ovf(ovf), .busy(busy)
  );

  mas_mac_vedic_16x16 #(.ACC_W(32), .LEN_W(8)) dut32 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready32), .in1(in1), .in2(in2),
    .out_valid(out_valid32), .out_ready(out_ready),
    .acc_res(acc_res32), .ovf(ovf32), .busy(busy32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y);
    in_valid = 1'b1;
    in1 = x;
    in2 = y;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {63'd0, out_valid}, 64'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0;
    in1 = 16'd0; in2 = 16'd0; out_ready = 1'b0;
    #3;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_acc", {24'd0, acc_res}, 64'd0);
    chk("rst_ovf_busy", {62'd0, ovf, busy}, 64'd0);
    #10 rst = 1'b0;
    tick();

    // 1: single pair, latency check
    start = 1'b1; len = 8'd1; tick(); start = 1'b0;
    chk("t1_in_ready_run", {63'd0, in_ready}, 64'd1);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    send(16'hFFFF, 16'hFFFF);
    chk("t1_in_ready_drop", {63'd0, in_ready}, 64'd0);
    for (int i = 1; i < MAS_MAC_PIPE_LAT; i++) begin
      chk("t1_out_valid_early", {63'd0, out_valid}, 64'd0);
      tick();
    end
    chk("t1_out_valid_early", {63'd0, out_valid}, 64'd0);
    tick();
    chk("t1_out_valid_lat3", {63'd0, out_valid}, 64'd1);
    chk("t1_acc", {24'd0, acc_res}, 64'hFFFE0001);
    chk("t1_ovf", {63'd0, ovf}, 64'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("t1_out_valid_drop", {63'd0, out_valid}, 64'd0);
    chk("t1_busy_idle", {63'd0, busy}, 64'd0);
    tick();
    chk("t1_acc_hold_idle", {24'd0, acc_res}, 64'hFFFE0001);

    // 2: four pairs back-to-back
    start = 1'b1; len = 8'd4; tick(); start = 1'b0;
    send(16'd1, 16'd2);
    send(16'd3, 16'd4);
    send(16'd5, 16'd6);
    chk("t2_in_ready_before_last", {63'd0, in_ready}, 64'd1);
    send(16'd7, 16'd8);
    chk("t2_in_ready_after_last", {63'd0, in_ready}, 64'd0);
    wait_out("t2_out_valid");
    chk("t2_acc", {24'd0, acc_res}, 64'd100);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // 3: zero-length job
    start = 1'b1; len = 8'd0; tick(); start = 1'b0;
    chk("t3_out_valid", {63'd0, out_valid}, 64'd1);
    chk("t3_acc", {24'd0, acc_res}, 64'd0);
    chk("t3_ovf", {63'd0, ovf}, 64'd0);
    chk("t3_in_ready", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("t3_out_valid_drop", {63'd0, out_valid}, 64'd0);

    // 4: gaps on input, stalled output, stray starts
    start = 1'b1; len = 8'd3; tick(); start = 1'b0;
    tick(); tick(); send(16'd100, 16'd200);
    start = 1'b1; len = 8'd5; tick(); start = 1'b0;
    chk("t4_busy_start_in_run", {63'd0, busy}, 64'd1);
    chk("t4_in_ready_gap", {63'd0, in_ready}, 64'd1);
    tick(); send(16'd300, 16'd400);
    tick(); tick(); send(16'h1234, 16'h0010);
    wait_out("t4_out_valid");
    start = 1'b1; len = 8'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      start = 1'b0;
      chk("t4_out_valid_held", {63'd0, out_valid}, 64'd1);
      chk("t4_acc_stable", {24'd0, acc_res}, 64'd214560);
    end
    chk("t4_busy_done", {63'd0, busy}, 64'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("t4_out_valid_drop", {63'd0, out_valid}, 64'd0);
    chk("t4_busy_idle", {63'd0, busy}, 64'd0);

    // 5: 32-bit wrap and ovf, then ovf cleared by next job
    start = 1'b1; len = 8'd2; tick(); start = 1'b0;
    send(16'hFFFF, 16'hFFFF);
    send(16'hFFFF, 16'hFFFF);
    wait_out("t5_out_valid");
    chk("t5_acc32", {32'd0, acc_res32}, 64'hFFFC0002);
    chk("t5_ovf32", {63'd0, ovf32}, 64'd1);
    chk("t5_acc40", {24'd0, acc_res}, 64'h1FFFC0002);
    chk("t5_ovf40", {63'd0, ovf}, 64'd0);
    chk("t5_out_valid32", {63'd0, out_valid32}, 64'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("t5_busy32_idle", {62'd0, busy32, in_ready32}, 64'd0);
    tick();
    chk("t5_ovf32_sticky_idle", {63'd0, ovf32}, 64'd1);
    start = 1'b1; len = 8'd1; tick(); start = 1'b0;
    send(16'd2, 16'd3);
    wait_out("t5b_out_valid");
    chk("t5b_acc32", {32'd0, acc_res32}, 64'd6);
    chk("t5b_ovf32", {63'd0, ovf32}, 64'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // 6: asynchronous reset in the middle of a job
    start = 1'b1; len = 8'd4; tick(); start = 1'b0;
    send(16'd10, 16'd20);
    send(16'd30, 16'd40);
    tick();
    chk("t6_acc_partial", {24'd0, acc_res}, 64'd200);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_in_ready", {63'd0, in_ready}, 64'd0);
    chk("t6_async_busy", {63'd0, busy}, 64'd0);
    chk("t6_async_acc", {24'd0, acc_res}, 64'd0);
    chk("t6_async_valid_ovf", {62'd0, out_valid, ovf}, 64'd0);
    #3 rst = 1'b0;
    tick();
    start = 1'b1; len = 8'd1; tick(); start = 1'b0;
    send(16'd10, 16'd10);
    wait_out("t6_out_valid");
    chk("t6_acc_fresh", {24'd0, acc_res}, 64'd100);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
